paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/game_pkg.sv | 42 ++++
 rtl/paddle_ctrl_if.sv | 26 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/paddle_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, playfield geometry and paddle position helpers
// Contents:
//   state_e    paddle movement FSM states
//   dir_e      requested movement direction
//   *_DEF      playfield defaults matching the border drawn by the pixel stage
//   xmin_f / xmax_f / reset_x_f  derived paddle column limits and start column
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  localparam int WALL_L_DEF   = 5;
  localparam int WALL_R_DEF   = 40;
  localparam int PADDLE_W_DEF = 6;
  localparam int PADDLE_Y_DEF = 29;

  // Leftmost legal paddle column: first cell inside the left wall.
  function automatic int xmin_f(input int wall_l);
    return wall_l + 1;
  endfunction

  // Rightmost legal paddle column: paddle's right edge lands just inside the right wall.
  function automatic int xmax_f(input int wall_r, input int paddle_w);
    return wall_r - paddle_w;
  endfunction

  // Centred start column.
  function automatic int reset_x_f(input int wall_l, input int wall_r, input int paddle_w);
    return (wall_l + wall_r + 1 - paddle_w) / 2;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - video scan / paddle result bundle between timing stage and paddle_ctrl
// Signals:
//   VSYNC       active-low vertical sync
//   DISPLAY_EN  visible-area flag
//   XMAP, YMAP  current map column / row
//   PADDLE_X    registered paddle left column
//   PADDLE_PIX  registered "current cell is paddle" flag
// Modports: master = timing/pixel side, slave = paddle_ctrl.
interface paddle_ctrl_if;
  logic       VSYNC;
  logic       DISPLAY_EN;
  logic [5:0] XMAP;
  logic [4:0] YMAP;
  logic [5:0] PADDLE_X;
  logic       PADDLE_PIX;

  modport master (
    output VSYNC, DISPLAY_EN, XMAP, YMAP,
    input  PADDLE_X, PADDLE_PIX
  );

  modport slave (
    input  VSYNC, DISPLAY_EN, XMAP, YMAP,
    output PADDLE_X, PADDLE_PIX
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser plus debounce counter for one raw button
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   raw    asynchronous button input, active-high
//   level  debounced button level
module btn_debounce
  import game_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic        sync1;
  logic        sync2;
  logic        sync2_d;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      sync2_d <= sync2;
      // Any movement of the synchronised level restarts the stability count;
      // once saturated the accepted level simply tracks the stable input.
      if (sync2 != sync2_d) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        level <= sync2_d;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - button-driven paddle position with auto-repeat and paddle pixel flag
// Ports:
//   CLK     system clock
//   RST_IN  synchronous active-high reset
//   LEFT    raw left button, active-high
//   RIGHT   raw right button, active-high
//   vid     paddle_ctrl_if.slave: VSYNC/DISPLAY_EN/XMAP/YMAP in, PADDLE_X/PADDLE_PIX out
module paddle_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          PADDLE_W        = PADDLE_W_DEF,
  parameter int          WALL_L          = WALL_L_DEF,
  parameter int          WALL_R          = WALL_R_DEF,
  parameter int          PADDLE_Y        = PADDLE_Y_DEF,
  parameter int          HOLD_FRAMES     = 12,
  parameter int          REPEAT_FRAMES   = 3
) (
  input  logic         CLK,
  input  logic         RST_IN,
  input  logic         LEFT,
  input  logic         RIGHT,
  paddle_ctrl_if.slave vid
);

  localparam logic [5:0] XMIN    = 6'(xmin_f(WALL_L));
  localparam logic [5:0] XMAX    = 6'(xmax_f(WALL_R, PADDLE_W));
  localparam logic [5:0] RESET_X = 6'(reset_x_f(WALL_L, WALL_R, PADDLE_W));

  logic       left_lvl;
  logic       right_lvl;
  logic       vsync_q;
  logic       frame;
  dir_e       dir;
  dir_e       dir_q;
  state_e     state;
  logic [7:0] fcnt;
  logic       step_l;
  logic       step_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (CLK),
    .rst   (RST_IN),
    .raw   (LEFT),
    .level (left_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (CLK),
    .rst   (RST_IN),
    .raw   (RIGHT),
    .level (right_lvl)
  );

  // History resets high so a frame only comes from a falling edge seen after reset.
  always_ff @(posedge CLK) begin
    if (RST_IN) vsync_q <= 1'b1;
    else        vsync_q <= vid.VSYNC;
  end

  assign frame = vsync_q & ~vid.VSYNC;

  always_comb begin
    dir = DIR_NONE;
    if (left_lvl && !right_lvl)      dir = DIR_LEFT;
    else if (right_lvl && !left_lvl) dir = DIR_RIGHT;
  end

  // Movement FSM. Steps are issued as one-clock registered requests, applied to
  // PADDLE_X the following clock, so the position only moves right after a frame.
  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state  <= ST_IDLE;
      dir_q  <= DIR_NONE;
      fcnt   <= '0;
      step_l <= 1'b0;
      step_r <= 1'b0;
    end else begin
      step_l <= 1'b0;
      step_r <= 1'b0;
      if (state != ST_IDLE && (dir == DIR_NONE || dir != dir_q)) begin
        state <= ST_IDLE;
        fcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dir != DIR_NONE) begin
              state <= ST_FIRST;
              dir_q <= dir;
            end
          end
          ST_FIRST: begin
            if (frame) begin
              step_l <= (dir_q == DIR_LEFT);
              step_r <= (dir_q == DIR_RIGHT);
              fcnt   <= '0;
              state  <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (frame) begin
              if (fcnt == 8'(HOLD_FRAMES - 1)) begin
                step_l <= (dir_q == DIR_LEFT);
                step_r <= (dir_q == DIR_RIGHT);
                fcnt   <= '0;
                state  <= ST_REPEAT;
              end else begin
                fcnt <= fcnt + 8'd1;
              end
            end
          end
          ST_REPEAT: begin
            if (frame) begin
              if (fcnt == 8'(REPEAT_FRAMES - 1)) begin
                step_l <= (dir_q == DIR_LEFT);
                step_r <= (dir_q == DIR_RIGHT);
                fcnt   <= '0;
              end else begin
                fcnt <= fcnt + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      vid.PADDLE_X <= RESET_X;
    end else if (step_r && vid.PADDLE_X < XMAX) begin
      vid.PADDLE_X <= vid.PADDLE_X + 6'd1;
    end else if (step_l && vid.PADDLE_X > XMIN) begin
      vid.PADDLE_X <= vid.PADDLE_X - 6'd1;
    end
  end

  // Widened to 7 bits so PADDLE_X + PADDLE_W - 1 never wraps past column 63.
  logic [6:0] x7;
  logic [6:0] px_lo;
  logic [6:0] px_hi;

  assign x7    = {1'b0, vid.XMAP};
  assign px_lo = {1'b0, vid.PADDLE_X};
  assign px_hi = px_lo + 7'(PADDLE_W - 1);

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      vid.PADDLE_PIX <= 1'b0;
    end else begin
      vid.PADDLE_PIX <= vid.DISPLAY_EN && (vid.YMAP == 5'(PADDLE_Y)) &&
                        (x7 >= px_lo) && (x7 <= px_hi);
    end
  end

endmodule
